half_beat_assembler: RTL and testbench

- Receive-side counterpart of the half-width sequential add/sub datapath.
- Accepts a stream of half-width result beats, low half first, each tagged with a half marker and carry-out.
- Reassembles each low/high pair into a full-width word with carry flag, presented on a valid/ready output.
- Detects out-of-order beats and counts delivered words.

---
 rtl/half_beat_assembler.sv | 177 +++++++++++++++++
 tb/tb_half_beat_assembler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/half_beat_assembler.sv
// Reassembles low/high half-width result beats into full-width words with carry on a valid/ready port.
// Optional SKID_BUF_EN adds a shadow word assembler so beats keep flowing while the output stalls.
module half_beat_assembler #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    beat_valid,
    input  logic [DATA_WIDTH/2-1:0] beat_data,
    input  logic                    beat_hi,
    input  logic                    beat_cout,
    output logic                    beat_ready,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [DATA_WIDTH-1:0]   word_data,
    output logic                    word_cout,
    output logic                    order_err,
    output logic [CNT_WIDTH-1:0]    word_cnt
);
    localparam int HW = DATA_WIDTH / 2;

    typedef enum logic [1:0] {ST_LO, ST_HI, ST_FULL} state_t;

    state_t                r_state, w_state_nxt;
    logic [HW-1:0]         r_lo, w_lo_nxt;
    logic [DATA_WIDTH-1:0] r_word, w_word_nxt;
    logic                  r_cout, w_cout_nxt;
    logic                  r_err, w_err_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_beat_acc;
    logic                  w_handoff;
    logic                  w_ready_st;

`ifdef SKID_BUF_EN
    state_t                r_sh_state, w_sh_state_nxt;
    logic [HW-1:0]         r_sh_lo, w_sh_lo_nxt;
    logic [DATA_WIDTH-1:0] r_sh_word, w_sh_word_nxt;
    logic                  r_sh_cout, w_sh_cout_nxt;

    assign w_ready_st = !((r_state == ST_FULL) && (r_sh_state == ST_FULL));
`else
    assign w_ready_st = (r_state != ST_FULL);
`endif

    // Gated with rst_n so beat_ready is low for the whole reset, not just after the first edge.
    assign beat_ready = rst_n & w_ready_st;
    assign word_valid = (r_state == ST_FULL);
    assign w_beat_acc = beat_valid & beat_ready;
    assign w_handoff  = word_valid & word_ready;
    assign word_data  = r_word;
    assign word_cout  = r_cout;
    assign order_err  = r_err;
    assign word_cnt   = r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_lo_nxt    = r_lo;
        w_word_nxt  = r_word;
        w_cout_nxt  = r_cout;
        w_err_nxt   = 1'b0;
`ifdef SKID_BUF_EN
        w_sh_state_nxt = r_sh_state;
        w_sh_lo_nxt    = r_sh_lo;
        w_sh_word_nxt  = r_sh_word;
        w_sh_cout_nxt  = r_sh_cout;
`endif
        case (r_state)
            ST_LO: begin
                if (w_beat_acc) begin
                    if (beat_hi) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_lo_nxt    = beat_data;
                        w_state_nxt = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (w_beat_acc) begin
                    if (beat_hi) begin
                        w_word_nxt  = {beat_data, r_lo};
                        w_cout_nxt  = beat_cout;
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_lo_nxt  = beat_data;
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_FULL: begin
`ifdef SKID_BUF_EN
                if (w_beat_acc) begin
                    case (r_sh_state)
                        ST_LO: begin
                            if (beat_hi) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_sh_lo_nxt    = beat_data;
                                w_sh_state_nxt = ST_HI;
                            end
                        end
                        ST_HI: begin
                            if (beat_hi) begin
                                w_sh_word_nxt  = {beat_data, r_sh_lo};
                                w_sh_cout_nxt  = beat_cout;
                                w_sh_state_nxt = ST_FULL;
                            end else begin
                                w_sh_lo_nxt = beat_data;
                                w_err_nxt   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                // On handoff the shadow (including a beat landing this edge) becomes the primary assembler.
                if (w_handoff) begin
                    case (w_sh_state_nxt)
                        ST_FULL: begin
                            w_word_nxt = w_sh_word_nxt;
                            w_cout_nxt = w_sh_cout_nxt;
                        end
                        ST_HI: begin
                            w_lo_nxt    = w_sh_lo_nxt;
                            w_state_nxt = ST_HI;
                        end
                        default: w_state_nxt = ST_LO;
                    endcase
                    w_sh_state_nxt = ST_LO;
                end
`else
                if (w_handoff) begin
                    w_state_nxt = ST_LO;
                end
`endif
            end
            default: w_state_nxt = ST_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LO;
            r_lo    <= '0;
            r_word  <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lo    <= w_lo_nxt;
            r_word  <= w_word_nxt;
            r_cout  <= w_cout_nxt;
            r_err   <= w_err_nxt;
            if (w_handoff) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef SKID_BUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_state <= ST_LO;
            r_sh_lo    <= '0;
            r_sh_word  <= '0;
            r_sh_cout  <= 1'b0;
        end else begin
            r_sh_state <= w_sh_state_nxt;
            r_sh_lo    <= w_sh_lo_nxt;
            r_sh_word  <= w_sh_word_nxt;
            r_sh_cout  <= w_sh_cout_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_half_beat_assembler.sv
// Self-checking bench for half_beat_assembler: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model; a second instance checks counter wrap.
module tb_half_beat_assembler;

`ifdef SKID_BUF_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = SKID ? 2 : 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beat_valid = 1'b0;
    logic [3:0] beat_data = 4'h0;
    logic       beat_hi = 1'b0;
    logic       beat_cout = 1'b0;
    logic       word_ready = 1'b0;

    logic        beat_ready, word_valid, word_cout, order_err;
    logic [7:0]  word_data;
    logic [15:0] word_cnt;
    logic        w_beat_ready, w_word_valid, w_word_cout, w_order_err;
    logic [7:0]  w_word_data;
    logic [1:0]  w_word_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    half_beat_assembler #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .beat_valid(beat_valid), .beat_data(beat_data),
        .beat_hi(beat_hi), .beat_cout(beat_cout), .beat_ready(beat_ready),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
        .word_cout(word_cout), .order_err(order_err), .word_cnt(word_cnt)
    );

    half_beat_assembler #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .beat_valid(beat_valid), .beat_data(beat_data),
        .beat_hi(beat_hi), .beat_cout(beat_cout), .beat_ready(w_beat_ready),
        .word_valid(w_word_valid), .word_ready(word_ready), .word_data(w_word_data),
        .word_cout(w_word_cout), .order_err(w_order_err), .word_cnt(w_word_cnt)
    );

    // Reference model: queue of completed words {cout, data} awaiting delivery plus an optional pending low half.
    logic [8:0]  m_words[$];
    bit          m_have_lo;
    logic [3:0]  m_lo;
    bit          m_err;
    int unsigned m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_words.delete();
        m_have_lo = 1'b0;
        m_lo      = 4'h0;
        m_err     = 1'b0;
        m_cnt     = 0;
    endtask

    task automatic model_step();
        bit rdy;
        bit acc;
        rdy   = (m_words.size() < CAP);
        acc   = beat_valid && rdy;
        m_err = 1'b0;
        if (m_words.size() > 0 && word_ready) begin
            void'(m_words.pop_front());
            m_cnt++;
        end
        if (acc) begin
            if (!beat_hi) begin
                if (m_have_lo) m_err = 1'b1;
                m_have_lo = 1'b1;
                m_lo      = beat_data;
            end else if (!m_have_lo) begin
                m_err = 1'b1;
            end else begin
                m_words.push_back({beat_cout, beat_data, m_lo});
                m_have_lo = 1'b0;
            end
        end
    endtask

    task automatic model_compare();
        check("beat_ready", beat_ready, 32'(m_words.size() < CAP));
        check("word_valid", word_valid, 32'(m_words.size() > 0));
        check("order_err", order_err, 32'(m_err));
        check("word_cnt", word_cnt, m_cnt % 65536);
        check("w_beat_ready", w_beat_ready, 32'(m_words.size() < CAP));
        check("w_word_valid", w_word_valid, 32'(m_words.size() > 0));
        check("w_order_err", w_order_err, 32'(m_err));
        check("w_word_cnt", w_word_cnt, m_cnt % 4);
        if (m_words.size() > 0) begin
            check("word_data", word_data, 32'(m_words[0][7:0]));
            check("word_cout", word_cout, 32'(m_words[0][8]));
            check("w_word_data", w_word_data, 32'(m_words[0][7:0]));
            check("w_word_cout", w_word_cout, 32'(m_words[0][8]));
        end
    endtask

    task automatic drive(input bit v, input bit hi, input logic [3:0] d, input bit c, input bit wr);
        beat_valid = v;
        beat_hi    = hi;
        beat_data  = d;
        beat_cout  = c;
        word_ready = wr;
        #1;
        model_compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic cycle(input bit v, input bit hi, input logic [3:0] d, input bit c, input bit wr);
        drive(v, hi, d, c, wr);
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_beat_ready"}, beat_ready, 0);
        check({tag, "_word_valid"}, word_valid, 0);
        check({tag, "_word_data"}, word_data, 0);
        check({tag, "_word_cout"}, word_cout, 0);
        check({tag, "_order_err"}, order_err, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
        check({tag, "_w_word_cnt"}, w_word_cnt, 0);
        check({tag, "_w_word_valid"}, w_word_valid, 0);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        beat_valid = 1'b0;
        word_ready = 1'b0;
        #1;
        check_zero("rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic        hi;
        logic [3:0]  d;
        logic        c;
        logic        wr;
        logic        rdy_ns;
        logic        rdy_sk;
        logic        wv;
        logic [7:0]  wd;
        logic        wc;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // v hi d c wr | rdy_ns rdy_sk wv wd wc err cnt  (expected before the edge)
        vecs[0] = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};
        vecs[4] = '{1'b1, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1};
        vecs[5] = '{1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};
        vecs[6] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd1};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0, 16'd1};
        vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0, 16'd1};
        vecs[9] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd2};

        @(negedge clk);
        do_reset();

        // Basic assembly and order-error vectors.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].hi, vecs[i].d, vecs[i].c, vecs[i].wr);
            check($sformatf("tbl%0d_ready", i), beat_ready, SKID ? vecs[i].rdy_sk : vecs[i].rdy_ns);
            check($sformatf("tbl%0d_valid", i), word_valid, vecs[i].wv);
            check($sformatf("tbl%0d_err", i), order_err, vecs[i].err);
            check($sformatf("tbl%0d_cnt", i), word_cnt, vecs[i].cnt);
            if (vecs[i].wv) begin
                check($sformatf("tbl%0d_data", i), word_data, vecs[i].wd);
                check($sformatf("tbl%0d_cout", i), word_cout, vecs[i].wc);
            end
            tick();
        end

        // Reset while a low half is held: that half must be discarded.
        cycle(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
        do_reset();
        cycle(1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("rstseq_err", order_err, 1);
        check("rstseq_valid", word_valid, 0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("rstseq_err_off", order_err, 0);
        check("rstseq_valid2", word_valid, 0);
        tick();

        // Backpressure: word 0xC3 held for five cycles while lo 0x1 / hi 0x2 are offered.
        cycle(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'hC, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 0)      drive(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
            else if (k == 1) drive(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
            else             drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
            check($sformatf("bp%0d_data", k), word_data, 8'hC3);
            check($sformatf("bp%0d_valid", k), word_valid, 1);
            check($sformatf("bp%0d_ready", k), beat_ready, SKID ? (k < 2) : 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("bp_hand_data", word_data, 8'hC3);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("bp_next_word", word_valid ? {1'b1, word_data} : 9'h000, SKID ? 9'h121 : 9'h000);
        tick();
        repeat (3) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Handoff and a low beat offered in the same FULL cycle.
        cycle(1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4'h5, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 4'h4, 1'b0, 1'b1);
        check("sim_ready", beat_ready, SKID);
        check("sim_data", word_data, 8'h56);
        tick();
        drive(1'b1, 1'b0, 4'h4, 1'b0, 1'b0);
        check("sim_ready_lo", beat_ready, 1);
        check("sim_valid_lo", word_valid, 0);
        tick();
        drive(1'b1, 1'b1, 4'h8, 1'b0, 1'b0);
        check("sim_err", order_err, SKID);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("sim_word", {word_valid, word_data}, 9'h184);
        tick();
        repeat (2) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Counter wrap on the 2-bit instance after five deliveries.
        do_reset();
        for (int w = 0; w < 5; w++) begin
            cycle(1'b1, 1'b0, 4'(w), 1'b0, 1'b1);
            cycle(1'b1, 1'b1, 4'(w + 8), 1'b1, 1'b1);
            cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        check("wrap_cnt2", w_word_cnt, 1);
        check("wrap_cnt16", word_cnt, 5);
        tick();

        // Randomized traffic against the model.
        for (int r = 0; r < 3000; r++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
        end
        repeat (4) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
